rs_sync_fifo_rd_stream: RTL and testbench
=========================================

# rs_sync_fifo_rd_stream

Read-side controller for the `rs_sync_fifo_afe` synchronous FIFO. It pops words from the FIFO and presents them on a valid/ready stream through a 2-entry output buffer. It compensates for the FIFO's registered `empty`/`almost_empty` flags, which lag the true occupancy. It sits between the FIFO and any downstream consumer in the same clock domain.

## Interface
- `DATA_WIDTH`, default 11: FIFO word width; must equal the FIFO's data width.
- `BURST_EN`, default 1: allow back-to-back pops while `fifo_almost_empty` is low. When `BURST_EN`=1, the FIFO's almost-empty threshold must be ≥2.
- `CNT_WIDTH`, default 16: width of the delivered-word counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `fifo_empty`  in  1: FIFO registered empty flag.
- `fifo_almost_empty`  in  1: FIFO registered almost-empty flag.
- `fifo_rd_data`  in  DATA_WIDTH: FIFO read data; combinational from the read pointer and valid in the same cycle as `fifo_rd_en`.
- `fifo_rd_en`  out  1: pop strobe; one word per asserted cycle.
- `flush`  in  1: synchronous clear of the output buffer and the pop pacing.
- `m_data`  out  DATA_WIDTH: stream data.
- `m_valid`  out  1: stream valid.
- `m_ready`  in  1: stream ready.
- `rd_count`  out  CNT_WIDTH: words accepted downstream; wraps modulo 2^CNT_WIDTH.

## Operation
- The FIFO `empty` flag reflects occupancy with a one-cycle lag after a pop. For this reason a pop is never issued on `fifo_empty` alone in the cycle right after a pop.
- Pacing FSM, driven from registered state:
  - IDLE: no pop last cycle. Pop if `!fifo_empty`. Next state is BLANK, or BURST if `BURST_EN && !fifo_almost_empty`.
  - BLANK: popped last cycle in paced mode. No pop this cycle. Next state is IDLE.
  - BURST: popped last cycle with `almost_empty` low. Pop if `!fifo_almost_empty`. Next state is BURST; if no pop, next state is IDLE.
  - Any state with no pop issued goes to IDLE.
- Pop qualifier: `fifo_rd_en` = FSM permits && buffer occupancy < 2 && `!flush`. `fifo_rd_en` is combinational from registered state and the registered FIFO flags only. It has no path from `m_ready`.
- The popped word is captured into the output buffer at the same clock edge.
- Output buffer: 2-entry register FIFO.
  - `m_data` always shows the head entry.
  - `m_valid` = occupancy ≠ 0.
  - A capture and a downstream accept in the same cycle keep occupancy unchanged, with order preserved.
  - `m_data` holds stable while `m_valid && !m_ready`.
- `rd_count` increments by 1 on each `m_valid && m_ready` cycle.
- `flush`:
  - At the next edge, buffer occupancy goes to 0 and the FSM goes to IDLE.
  - `fifo_rd_en` is held low during the flush cycle.
  - Buffered words are discarded, and a handshake in the flush cycle is not counted.
  - `rd_count` is not cleared.
- Reset mid-operation: immediate clear of all state. Buffer contents are discarded. The FIFO is reset by the same `rst_n`.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `rd_count`=0, FSM=IDLE, `fifo_rd_en`=0 (follows from IDLE/occupancy only after the FIFO flags leave reset).
- Latency: a pop in cycle N gives `m_valid`=1 in cycle N+1.
- Throughput:
  - Paced mode: 1 word per 2 cycles.
  - BURST: 1 word per cycle with `m_ready` held high.
- Backpressure: with `m_ready`=0, at most 2 words are popped, then `fifo_rd_en` stays 0 until a slot frees. That slot is visible the cycle after the accept.
- No pop while `fifo_empty`=1 in IDLE. No pop in BLANK regardless of flags.

## Test plan
- Reset, then FIFO with 1 word, `m_ready`=1. Required: pop in cycle 1, `m_valid` in cycle 2, no second pop in cycle 2 (BLANK), `rd_count`=1, no further pops once `fifo_empty`=1.
- FIFO preloaded with 8 words, threshold 2, `BURST_EN`=1, `m_ready`=1. Required: back-to-back pops until `almost_empty` asserts, then 1-in-2 pacing, 8 words in order, zero extra pops, `rd_count`=8.
- `BURST_EN`=0, 4 words. Required: `fifo_rd_en` pattern 1,0,1,0,1,0,1, data in order.
- `m_ready`=0 with 5 words available. Required: exactly 2 pops, `m_data` stable, then `m_ready`=1 drains all 5 in order.
- `flush` with 2 words buffered and `m_ready`=1. Required: `m_valid`=0 next cycle, no pop during the flush cycle, `rd_count` unchanged by the flush-cycle handshake, popping resumes from IDLE.
- `rd_count` wrap with `CNT_WIDTH`=4: 17 accepts gives `rd_count`=1. `rst_n` pulsed mid-burst gives all outputs at reset values asynchronously.

Source files
------------

// File: rtl/rs_sync_fifo_rd_stream.sv
// Read-side pop controller for a synchronous FIFO with lagging registered flags,
// delivering words on a valid/ready stream through a 2-entry output buffer.
module rs_sync_fifo_rd_stream #(
  parameter int DATA_WIDTH = 11,
  parameter int BURST_EN   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  typedef enum logic [1:0] {IDLE, BLANK, BURST} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  permit;
  logic                  pop;
  logic                  accept;

  always_comb begin
    permit = 1'b0;
    case (state_q)
      IDLE:    permit = !fifo_empty;
      BLANK:   permit = 1'b0;
      BURST:   permit = !fifo_almost_empty;
      default: permit = 1'b0;
    endcase

    // No m_ready term here: a free slot only becomes visible after the accept edge.
    pop    = permit && (occ_q != 2'd2) && !flush;
    accept = (occ_q != 2'd0) && m_ready && !flush;

    if (!pop)
      state_d = IDLE;
    else if ((BURST_EN != 0) && !fifo_almost_empty)
      state_d = BURST;
    else
      state_d = BLANK;

    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      case ({pop, accept})
        2'b10: begin
          if (occ_q == 2'd0) head_d = fifo_rd_data;
          else               tail_d = fifo_rd_data;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous capture and accept: shift, new word lands behind any survivor.
          if (occ_q == 2'd1) begin
            head_d = fifo_rd_data;
          end else begin
            head_d = tail_q;
            tail_d = fifo_rd_data;
          end
        end
        default: ;
      endcase
    end

    cnt_d = cnt_q + (accept ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_rd_en = pop;
  assign m_data     = head_q;
  assign m_valid    = (occ_q != 2'd0);
  assign rd_count   = cnt_q;

endmodule

// File: tb/tb_rs_sync_fifo_rd_stream.sv
// Randomized and directed bench for rs_sync_fifo_rd_stream against a FIFO model
// with lagging registered flags and a word-level scoreboard of the output stream.
module tb_rs_sync_fifo_rd_stream;

  localparam int DW = 11;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fe = 1'b1;
  logic          fae = 1'b1;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          flush = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] rd_count;

  logic          pc_rd_en;
  logic [DW-1:0] pc_m_data;
  logic          pc_m_valid;
  logic [15:0]   pc_rd_count;

  logic [DW-1:0] mem [1024];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            th = 2;

  logic [DW-1:0] exp_q [$];
  logic [CW-1:0] exp_cnt = '0;
  logic          last_pop = 1'b0;
  logic          last_ae_low = 1'b0;
  logic          pc_exp = 1'b1;
  logic [31:0]   trace = '0;
  int            run = 0;
  int            max_run = 0;

  int            n_chk = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  assign fifo_rd_data = mem[rd_ptr[9:0]];

  rs_sync_fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_EN(1), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fe), .fifo_almost_empty(fae),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .flush(flush),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .rd_count(rd_count)
  );

  // Paced-only instance facing a FIFO that never runs low.
  rs_sync_fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_EN(0), .CNT_WIDTH(16)) dut_pc (
    .clk(clk), .rst_n(rst_n), .fifo_empty(1'b0), .fifo_almost_empty(1'b0),
    .fifo_rd_data(11'h5a5), .fifo_rd_en(pc_rd_en), .flush(1'b0),
    .m_data(pc_m_data), .m_valid(pc_m_valid), .m_ready(1'b1), .rd_count(pc_rd_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_cnt     = '0;
    last_pop    = 1'b0;
    last_ae_low = 1'b0;
    fe          = 1'b1;
    fae         = 1'b1;
    wr_ptr      = 0;
    rd_ptr      = 0;
    pc_exp      = 1'b1;
  endtask

  task automatic wr_word(input logic [DW-1:0] v);
    mem[wr_ptr[9:0]] = v;
    wr_ptr++;
  endtask

  // One clock: check outputs mid-cycle, then advance the model past the edge.
  task automatic tick();
    logic rd_s, acc_s, fl_s, exp_rd;
    int   pre;
    @(negedge clk);
    rd_s  = fifo_rd_en;
    acc_s = m_valid && m_ready;
    fl_s  = flush;
    check("m_valid", m_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("m_data", m_data, exp_q[0]);
    check("rd_count", rd_count, exp_cnt);
    exp_rd = rst_n && !flush && (exp_q.size() < 2) && (last_pop ? (last_ae_low && !fae) : !fe);
    check("fifo_rd_en", fifo_rd_en, exp_rd);
    if (rd_s) check("underflow", (wr_ptr - rd_ptr) > 0, 1);
    if (rst_n) check("paced_rd_en", pc_rd_en, pc_exp);
    trace = {trace[30:0], rd_s};
    run = rd_s ? run + 1 : 0;
    if (run > max_run) max_run = run;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      pre = wr_ptr - rd_ptr;
      if (acc_s && !fl_s) begin
        void'(exp_q.pop_front());
        exp_cnt = exp_cnt + 1'b1;
      end
      if (fl_s) exp_q.delete();
      if (rd_s) begin
        exp_q.push_back(mem[rd_ptr[9:0]]);
        rd_ptr++;
      end
      last_pop    = rd_s;
      last_ae_low = !fae;
      fe          = (pre == 0);
      fae         = (pre <= th);
      pc_exp      = !pc_exp;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [DW-1:0] w [5];
    logic [CW-1:0] cnt_before;
    int            rd0;

    model_reset();
    #3;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    ticks(2);
    rst_n = 1'b1;

    // Single word
    m_ready = 1'b1;
    rd0 = rd_ptr;
    trace = '0;
    wr_word(11'h123);
    ticks(8);
    check("t1_trace", trace[7:0], 8'b0100_0000);
    check("t1_pops", rd_ptr - rd0, 1);
    check("t1_count", rd_count, 1);

    // Burst then pacing
    th = 2;
    max_run = 0;
    rd0 = rd_ptr;
    for (int i = 0; i < 8; i++) wr_word(DW'(11'h200 + i));
    ticks(16);
    check("t2_max_run", max_run, 7);
    check("t2_pops", rd_ptr - rd0, 8);
    check("t2_count", rd_count, 9);

    // Paced only (threshold above occupancy)
    th = 15;
    ticks(2);
    trace = '0;
    for (int i = 0; i < 4; i++) wr_word(DW'(11'h300 + i));
    ticks(12);
    check("t3_trace", trace[11:0], 12'h550);

    // Backpressure
    th = 2;
    m_ready = 1'b0;
    rd0 = rd_ptr;
    for (int i = 0; i < 5; i++) begin
      w[i] = DW'($urandom_range(1, 2047));
      wr_word(w[i]);
    end
    ticks(4);
    check("t4_head", m_data, w[0]);
    ticks(4);
    check("t4_pops_held", rd_ptr - rd0, 2);
    check("t4_head_stable", m_data, w[0]);
    m_ready = 1'b1;
    ticks(20);
    check("t4_pops_all", rd_ptr - rd0, 5);

    // Flush with two words buffered
    m_ready = 1'b0;
    rd0 = rd_ptr;
    for (int i = 0; i < 4; i++) wr_word(DW'(11'h400 + i));
    ticks(6);
    check("t5_buffered", rd_ptr - rd0, 2);
    cnt_before = exp_cnt;
    m_ready = 1'b1;
    flush = 1'b1;
    #1;
    check("t5_flush_rd_en", fifo_rd_en, 0);
    tick();
    flush = 1'b0;
    check("t5_valid_after", m_valid, 0);
    check("t5_count_kept", rd_count, cnt_before);
    ticks(15);
    check("t5_resume", rd_ptr - rd0, 4);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 10; i++) wr_word(DW'($urandom_range(1, 2047)));
    ticks(4);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_m_data", m_data, 0);
    check("arst_rd_count", rd_count, 0);
    check("arst_rd_en", fifo_rd_en, 0);
    ticks(2);
    rst_n = 1'b1;

    // Counter wrap at 4 bits
    for (int i = 0; i < 17; i++) wr_word(DW'($urandom_range(1, 2047)));
    ticks(50);
    check("wrap_count", rd_count, 1);

    // Random traffic
    th = $urandom_range(2, 4);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) wr_word(DW'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 19) == 0);
      tick();
    end
    flush = 1'b0;
    m_ready = 1'b1;
    ticks(60);
    check("rand_drained", rd_ptr, wr_ptr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
